// File: rtl/aproximacion_sucesiva_pkg.sv
// Shared definitions for the successive-approximation search and its comparator family.
package aproximacion_sucesiva_pkg;

   // Search FSM encoding, exported on the debug port of the top module.
   typedef enum logic [2:0] {
      REPOSO  = 3'd0,
      PROBAR  = 3'd1,
      ESPERAR = 3'd2,
      DECIDIR = 3'd3,
      FIN     = 3'd4
   } estado_t;

   // Default sizing shared with the threshold comparators: two decimal digits.
   localparam int ANCHO_DEF    = 7;
   localparam int MAXIMO_DEF   = 99;
   localparam int LATENCIA_DEF = 0;

   // Width needed to hold a bit index 0..ancho-1 (never narrower than one bit).
   function automatic int ancho_indice(input int ancho);
      return (ancho > 1) ? $clog2(ancho) : 1;
   endfunction

   // Width of the wait counter, which is loaded with latencia-1.
   function automatic int ancho_espera(input int latencia);
      return (latencia > 1) ? $clog2(latencia) : 1;
   endfunction

endpackage

// File: rtl/aproximacion_sucesiva_espera.sv
// Loadable down-counter that paces the comparator settling time.
// Loading happens while the FSM sits in PROBAR; it then counts down once per
// ESPERAR cycle and 'cero' tells the FSM the comparator answer is settled.
module contador_espera
   import aproximacion_sucesiva_pkg::*;
#(
   parameter int ANCHO_CNT = 1
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 cargar_i,
   input  logic                 decrementar_i,
   input  logic [ANCHO_CNT-1:0] valor_i,
   output logic                 cero_o
);

   logic [ANCHO_CNT-1:0] cuenta_q;
   logic [ANCHO_CNT-1:0] cuenta_d;

   // Next count: load has priority, decrement saturates at zero.
   always_comb begin
      cuenta_d = cuenta_q;
      if (cargar_i) begin
         cuenta_d = valor_i;
      end else if (decrementar_i && (cuenta_q != '0)) begin
         cuenta_d = cuenta_q - ANCHO_CNT'(1);
      end
   end

   // Count register, cleared by the synchronous reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cuenta_q <= '0;
      end else begin
         cuenta_q <= cuenta_d;
      end
   end

   assign cero_o = (cuenta_q == '0);

endmodule

// File: rtl/aproximacion_sucesiva.sv
// Successive-approximation search: rebuilds an unknown value 0..MAXIMO MSB first
// by presenting trial values to an external magnitude comparator.
//
// Handshake: Inicio is level-sampled at each rising edge and is only accepted in
// REPOSO or FIN; the accepting edge raises Ocupado and drops Listo. Listo rises
// ANCHO*(LATENCIA_CMP+2) edges later together with Resultado, and both hold until
// the next accepted Inicio. Comparacion is only looked at in DECIDIR.
module aproximacion_sucesiva
   import aproximacion_sucesiva_pkg::*;
#(
   parameter int ANCHO        = ANCHO_DEF,
   parameter int MAXIMO       = MAXIMO_DEF,
   parameter int LATENCIA_CMP = LATENCIA_DEF
) (
   input  logic             Reloj,
   input  logic             Reset,
   input  logic             Inicio,
   input  logic             Comparacion,
   output logic [ANCHO-1:0] Prueba,
   output logic [ANCHO-1:0] Resultado,
   output logic             Ocupado,
   output logic             Listo,
   output estado_t          estado_o
);

   localparam int               IDX_W    = ancho_indice(ANCHO);
   localparam logic [IDX_W-1:0] IDX_MSB  = IDX_W'(ANCHO - 1);
   localparam logic [ANCHO-1:0] MAX_V    = ANCHO'(MAXIMO);
   localparam logic [ANCHO-1:0] UNO      = ANCHO'(1);
   localparam logic [ANCHO-1:0] PRIMERA  = UNO << (ANCHO - 1);
   // The very first trial is clamped the same way as every later one.
   localparam logic [ANCHO-1:0] PRUEBA_INI = (PRIMERA > MAX_V) ? '0 : PRIMERA;

   estado_t          estado_q;
   logic [ANCHO-1:0] acc_q;
   logic [IDX_W-1:0] idx_q;
   logic [ANCHO-1:0] prueba_q;
   logic [ANCHO-1:0] resultado_q;
   logic             ocupado_q;
   logic             listo_q;

   logic [ANCHO-1:0] bit_actual;
   logic [ANCHO-1:0] prueba_actual;
   logic             fuera_rango;
   logic             bit_decidido;
   logic [ANCHO-1:0] acc_d;
   logic [ANCHO-1:0] siguiente;
   logic [ANCHO-1:0] prueba_d;
   logic             espera_cero;

   // Decision datapath: the bit under test, the clamp, and the next trial value.
   // A trial above MAXIMO is never shown; its bit is forced to 0 and the
   // comparator sees the accumulated value instead.
   always_comb begin
      bit_actual    = UNO << idx_q;
      prueba_actual = acc_q | bit_actual;
      fuera_rango   = (prueba_actual > MAX_V);
      bit_decidido  = Comparacion & ~fuera_rango;
      acc_d         = bit_decidido ? prueba_actual : acc_q;
      siguiente     = acc_d | (bit_actual >> 1);
      prueba_d      = (siguiente > MAX_V) ? acc_d : siguiente;
   end

   // Settling-time counter only exists when the comparator needs extra cycles.
   if (LATENCIA_CMP > 0) begin : g_espera
      localparam int EW = ancho_espera(LATENCIA_CMP);
      logic cargar;
      logic decrementar;
      assign cargar      = (estado_q == PROBAR);
      assign decrementar = (estado_q == ESPERAR);
      contador_espera #(
         .ANCHO_CNT (EW)
      ) u_espera (
         .clk_i         (Reloj),
         .rst_i         (Reset),
         .cargar_i      (cargar),
         .decrementar_i (decrementar),
         .valor_i       (EW'(LATENCIA_CMP - 1)),
         .cero_o        (espera_cero)
      );
   end else begin : g_sin_espera
      assign espera_cero = 1'b1;
   end

   // Search FSM with its accumulator, bit index and registered outputs.
   always_ff @(posedge Reloj) begin
      if (Reset) begin
         estado_q    <= REPOSO;
         acc_q       <= '0;
         idx_q       <= IDX_MSB;
         prueba_q    <= '0;
         resultado_q <= '0;
         ocupado_q   <= 1'b0;
         listo_q     <= 1'b0;
      end else begin
         case (estado_q)
            REPOSO, FIN: begin
               if (Inicio) begin
                  estado_q  <= PROBAR;
                  acc_q     <= '0;
                  idx_q     <= IDX_MSB;
                  prueba_q  <= PRUEBA_INI;
                  ocupado_q <= 1'b1;
                  listo_q   <= 1'b0;
               end
            end
            PROBAR: begin
               // Trial is already on Prueba; give the comparator its settling time.
               estado_q <= (LATENCIA_CMP == 0) ? DECIDIR : ESPERAR;
            end
            ESPERAR: begin
               if (espera_cero) begin
                  estado_q <= DECIDIR;
               end
            end
            DECIDIR: begin
               acc_q <= acc_d;
               if (idx_q == '0) begin
                  estado_q    <= FIN;
                  resultado_q <= acc_d;
                  listo_q     <= 1'b1;
                  ocupado_q   <= 1'b0;
                  prueba_q    <= '0;
               end else begin
                  estado_q <= PROBAR;
                  idx_q    <= idx_q - IDX_W'(1);
                  prueba_q <= prueba_d;
               end
            end
            default: begin
               estado_q <= REPOSO;
            end
         endcase
      end
   end

   assign Prueba    = prueba_q;
   assign Resultado = resultado_q;
   assign Ocupado   = ocupado_q;
   assign Listo     = listo_q;
   assign estado_o  = estado_q;

endmodule

// File: tb/tb_aproximacion_sucesiva.sv
// Bench for the successive-approximation search: one instance with an immediate
// comparator, one with a two-cycle registered comparator.
module tb_aproximacion_sucesiva;
   import aproximacion_sucesiva_pkg::*;

   // ---------------- clock / reset ----------------
   logic clk   = 1'b0;
   logic reset = 1'b1;
   int   cyc   = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus signals ----------------
   logic       inicio = 1'b0;
   logic       sel    = 1'b0;   // 0: instance without latency, 1: LATENCIA_CMP=2
   logic       stuck  = 1'b0;   // comparator answer forced to 1
   logic [6:0] unk    = 7'd0;

   logic       inicio0, inicio2, comp0, comp2;
   logic [6:0] prueba0, prueba2, resultado0, resultado2;
   logic       ocupado0, ocupado2, listo0, listo2;
   estado_t    estado0, estado2;
   logic       cmp_s1 = 1'b0;
   logic       cmp_s2 = 1'b0;

   assign inicio0 = inicio & ~sel;
   assign inicio2 = inicio & sel;

   // Behavioural comparators: immediate, and two registered stages.
   assign comp0 = stuck | (unk >= prueba0);
   always @(posedge clk) begin
      cmp_s1 <= (unk >= prueba2);
      cmp_s2 <= cmp_s1;
   end
   assign comp2 = cmp_s2;

   aproximacion_sucesiva #(.ANCHO(7), .MAXIMO(99), .LATENCIA_CMP(0)) dut0 (
      .Reloj       (clk),
      .Reset       (reset),
      .Inicio      (inicio0),
      .Comparacion (comp0),
      .Prueba      (prueba0),
      .Resultado   (resultado0),
      .Ocupado     (ocupado0),
      .Listo       (listo0),
      .estado_o    (estado0)
   );

   aproximacion_sucesiva #(.ANCHO(7), .MAXIMO(99), .LATENCIA_CMP(2)) dut2 (
      .Reloj       (clk),
      .Reset       (reset),
      .Inicio      (inicio2),
      .Comparacion (comp2),
      .Prueba      (prueba2),
      .Resultado   (resultado2),
      .Ocupado     (ocupado2),
      .Listo       (listo2),
      .estado_o    (estado2)
   );

   logic [6:0] prueba_m, resultado_m;
   logic       ocupado_m, listo_m;
   estado_t    estado_m;
   assign prueba_m    = sel ? prueba2    : prueba0;
   assign resultado_m = sel ? resultado2 : resultado0;
   assign ocupado_m   = sel ? ocupado2   : ocupado0;
   assign listo_m     = sel ? listo2     : listo0;
   assign estado_m    = sel ? estado2    : estado0;

   // ---------------- scoreboard ----------------
   int         errors = 0;
   int         checks = 0;
   logic [6:0] exp_q[$];       // expected Resultado per search
   int         exp_edge_q[$];  // expected cycle count when Listo rises
   logic [6:0] exp_pru_q[$];   // expected Prueba sequence (optional per search)

   task automatic check(input string nombre, input logic [31:0] actual, input logic [31:0] esperado);
      checks++;
      if (actual !== esperado) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", nombre, actual, esperado, cyc);
      end
   endtask

   // ---------------- monitor ----------------
   logic       listo_prev = 1'b0;
   logic       pru_on     = 1'b0;
   logic [6:0] pru_cur    = 7'd0;
   logic [6:0] mon_res;
   int         mon_edge;
   logic [6:0] mon_pru;

   always @(negedge clk) begin
      if (reset) begin
         listo_prev <= 1'b0;
         pru_on     <= 1'b0;
      end else begin
         if (listo_m && !listo_prev) begin
            check("cola_resultados", 32'(exp_q.size() != 0), 32'(1));
            if (exp_q.size() != 0) begin
               mon_res  = exp_q.pop_front();
               mon_edge = exp_edge_q.pop_front();
               check("resultado", 32'(resultado_m), 32'(mon_res));
               check("flanco_listo", 32'(cyc), 32'(mon_edge));
               check("ocupado_fin", 32'(ocupado_m), 32'(0));
               check("prueba_fin", 32'(prueba_m), 32'(0));
            end
         end
         if (estado_m == PROBAR) begin
            if (exp_pru_q.size() != 0) begin
               mon_pru = exp_pru_q.pop_front();
               check("prueba", 32'(prueba_m), 32'(mon_pru));
               pru_cur <= mon_pru;
               pru_on  <= 1'b1;
            end else begin
               pru_on <= 1'b0;
            end
         end else if ((estado_m == ESPERAR || estado_m == DECIDIR) && pru_on) begin
            check("prueba_sostenida", 32'(prueba_m), 32'(pru_cur));
         end
         listo_prev <= listo_m;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic cargar_pruebas(input logic [6:0] a, b, c, d, e, f, g);
      exp_pru_q.push_back(a); exp_pru_q.push_back(b); exp_pru_q.push_back(c);
      exp_pru_q.push_back(d); exp_pru_q.push_back(e); exp_pru_q.push_back(f);
      exp_pru_q.push_back(g);
   endtask

   // Wait until every queued result has been seen and the search is idle.
   task automatic esperar_fin(input int budget);
      int n = 0;
      while ((exp_q.size() != 0 || ocupado_m) && n < budget) begin
         @(negedge clk);
         n++;
      end
      check("fin_a_tiempo", 32'(n < budget), 32'(1));
      if (n >= budget) begin
         exp_q.delete();
         exp_edge_q.delete();
         exp_pru_q.delete();
      end
      @(negedge clk);
      check("listo_mantenido", 32'(listo_m), 32'(1));
   endtask

   // One search; called at a falling edge, Inicio is taken at the next rising edge.
   task automatic buscar(input logic [6:0] unk_v, input logic [6:0] res_v, input int lat);
      unk    = unk_v;
      inicio = 1'b1;
      @(negedge clk);
      inicio = 1'b0;
      exp_q.push_back(res_v);
      exp_edge_q.push_back(cyc + lat);
      check("ocupado_arranque", 32'(ocupado_m), 32'(1));
      check("listo_baja", 32'(listo_m), 32'(0));
      esperar_fin(lat + 20);
   endtask

   // ---------------- directed sequence ----------------
   int base;

   initial begin
      repeat (3) @(negedge clk);
      reset = 1'b0;
      check("reset_prueba0", 32'(prueba0), 32'(0));
      check("reset_resultado0", 32'(resultado0), 32'(0));
      check("reset_ocupado0", 32'(ocupado0), 32'(0));
      check("reset_listo0", 32'(listo0), 32'(0));
      check("reset_estado0", 32'(estado0), 32'(REPOSO));
      check("reset_estado2", 32'(estado2), 32'(REPOSO));
      @(negedge clk);

      // Immediate comparator: directed unknowns with hand-derived trial sequences.
      cargar_pruebas(7'd64, 7'd96, 7'd80, 7'd72, 7'd76, 7'd74, 7'd73);
      buscar(7'd73, 7'd73, 14);
      cargar_pruebas(7'd64, 7'd32, 7'd16, 7'd8, 7'd4, 7'd2, 7'd1);
      buscar(7'd0, 7'd0, 14);
      cargar_pruebas(7'd64, 7'd96, 7'd96, 7'd96, 7'd96, 7'd98, 7'd99);
      buscar(7'd99, 7'd99, 14);

      // Comparator stuck at 1: trials 112, 104, 100 must be replaced by 96.
      stuck = 1'b1;
      cargar_pruebas(7'd64, 7'd96, 7'd96, 7'd96, 7'd96, 7'd98, 7'd99);
      buscar(7'd5, 7'd99, 14);
      stuck = 1'b0;

      cargar_pruebas(7'd64, 7'd96, 7'd80, 7'd72, 7'd68, 7'd66, 7'd65);
      buscar(7'd64, 7'd64, 14);
      buscar(7'd1, 7'd1, 14);
      buscar(7'd50, 7'd50, 14);

      // Inicio pulses at edges 3 and 9 of a running search are ignored.
      unk    = 7'd42;
      inicio = 1'b1;
      @(negedge clk);
      inicio = 1'b0;
      base   = cyc;
      exp_q.push_back(7'd42);
      exp_edge_q.push_back(base + 14);
      while (cyc != base + 2) @(negedge clk);
      inicio = 1'b1;
      @(negedge clk);
      inicio = 1'b0;
      while (cyc != base + 8) @(negedge clk);
      inicio = 1'b1;
      @(negedge clk);
      inicio = 1'b0;
      esperar_fin(40);

      // Reset at edge 5 of a search aborts it and clears every output.
      unk    = 7'd50;
      inicio = 1'b1;
      @(negedge clk);
      inicio = 1'b0;
      base   = cyc;
      while (cyc != base + 4) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("abort_prueba", 32'(prueba0), 32'(0));
      check("abort_resultado", 32'(resultado0), 32'(0));
      check("abort_ocupado", 32'(ocupado0), 32'(0));
      check("abort_listo", 32'(listo0), 32'(0));
      check("abort_estado", 32'(estado0), 32'(REPOSO));
      cargar_pruebas(7'd64, 7'd96, 7'd80, 7'd72, 7'd76, 7'd74, 7'd73);
      buscar(7'd73, 7'd73, 14);

      // Inicio held high: back-to-back searches, Listo pulses 15 cycles apart.
      unk    = 7'd85;
      inicio = 1'b1;
      @(negedge clk);
      base = cyc;
      exp_q.push_back(7'd85);
      exp_edge_q.push_back(base + 14);
      exp_q.push_back(7'd85);
      exp_edge_q.push_back(base + 29);
      while (cyc != base + 15) @(negedge clk);
      check("listo_un_ciclo", 32'(listo_m), 32'(0));
      check("reinicio_ocupado", 32'(ocupado_m), 32'(1));
      while (cyc != base + 29) @(negedge clk);
      inicio = 1'b0;
      esperar_fin(20);

      // Two-cycle comparator: each trial held four cycles, Listo at edge 28.
      sel = 1'b1;
      @(negedge clk);
      cargar_pruebas(7'd64, 7'd32, 7'd48, 7'd40, 7'd36, 7'd38, 7'd37);
      buscar(7'd37, 7'd37, 28);
      cargar_pruebas(7'd64, 7'd96, 7'd96, 7'd96, 7'd96, 7'd98, 7'd99);
      buscar(7'd99, 7'd99, 28);
      buscar(7'd6, 7'd6, 28);

      repeat (3) @(negedge clk);
      check("cola_resultados_vacia", 32'(exp_q.size()), 32'(0));
      check("cola_pruebas_vacia", 32'(exp_pru_q.size()), 32'(0));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
